// File: rtl/deflate_bit_reader.sv
// LSB-first bit reader: buffers 512-bit stream words and presents a WIN_W-bit peek window.
// Define BIT_READER_STATS_EN to add the saturating total_bits retired-bit counter output.
module deflate_bit_reader #(
    parameter int WIN_W = 32,
    parameter int BUF_W = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [511:0]     in_data,
    input  logic             in_last,
    input  logic [8:0]       in_last_len,
    output logic             in_ready,
    input  logic [5:0]       consume_len,
    input  logic             align_req,
    output logic [WIN_W-1:0] win_data,
    output logic             win_valid,
    output logic [10:0]      fill_bits,
    output logic             done,
    output logic             err
`ifdef BIT_READER_STATS_EN
    ,
    output logic [31:0]      total_bits
`endif
);
    localparam logic [5:0]  CONS_MAX  = 6'(WIN_W);
    localparam logic [10:0] WIN_FILL  = 11'(WIN_W);
    localparam logic [10:0] READY_MAX = 11'(BUF_W - 512);
    localparam logic [10:0] WORD_BITS = 11'd512;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [BUF_W-1:0] bits_q, bits_d;
    logic [10:0]      fill_q, fill_d;
    logic [2:0]       bitpos_q, bitpos_d;
    logic             err_q, err_d;
    logic             done_q, done_d;

    logic [10:0]      cons_req, cons_eff, rem_bits, align_amt, drop, fill_eff, in_bits, shift_amt;
    logic [2:0]       bpos_cons, align_bits;
    logic [511:0]     word_mask;
    logic             accept, start_ok, viol;

    assign in_ready  = (state_q == S_RUN) && (fill_q <= READY_MAX);
    assign win_valid = (fill_q >= WIN_FILL) || ((state_q == S_DRAIN) && (fill_q != 11'd0));
    assign win_data  = bits_q[WIN_W-1:0];
    assign fill_bits = fill_q;
    assign done      = done_q;
    assign err       = err_q;

    always_comb begin
        // Consume is clamped to what is held; alignment then drops to the next byte boundary.
        cons_req   = {5'd0, consume_len};
        cons_eff   = (cons_req > fill_q) ? fill_q : cons_req;
        rem_bits   = fill_q - cons_eff;
        bpos_cons  = bitpos_q + cons_eff[2:0];
        align_bits = 3'd0 - bpos_cons;
        align_amt  = align_req ? {8'd0, align_bits} : 11'd0;
        drop       = (align_amt > rem_bits) ? rem_bits : align_amt;
        fill_eff   = rem_bits - drop;
        shift_amt  = cons_eff + drop;
        viol       = (consume_len > CONS_MAX) || (cons_req > fill_q) ||
                     ((consume_len != 6'd0) && !win_valid) || (align_amt > rem_bits);

        accept    = in_valid && in_ready;
        start_ok  = start && ((state_q == S_IDLE) || (state_q == S_DONE));

        in_bits   = WORD_BITS;
        word_mask = '1;
        if (in_last && (in_last_len != 9'd0)) begin
            in_bits   = {2'd0, in_last_len};
            word_mask = ~({512{1'b1}} << in_last_len);
        end

        bits_d = bits_q >> shift_amt;
        fill_d = fill_eff;
        if (accept) begin
            bits_d = bits_d | ({{(BUF_W-512){1'b0}}, in_data & word_mask} << fill_eff);
            fill_d = fill_eff + in_bits;
        end

        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: if (start_ok) state_d = S_RUN;
            S_RUN:          if (accept && in_last) state_d = S_DRAIN;
            S_DRAIN: begin
                if (fill_d == 11'd0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            default:        state_d = S_IDLE;
        endcase

        err_d    = start_ok ? 1'b0 : (err_q | viol);
        bitpos_d = start_ok ? 3'd0 : (bpos_cons + drop[2:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            bits_q   <= '0;
            fill_q   <= '0;
            bitpos_q <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bits_q   <= bits_d;
            fill_q   <= fill_d;
            bitpos_q <= bitpos_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

`ifdef BIT_READER_STATS_EN
    logic [31:0] total_q, total_d;
    logic [32:0] total_sum;

    always_comb begin
        total_sum = {1'b0, total_q} + {22'd0, shift_amt};
        if (start_ok)          total_d = '0;
        else if (total_sum[32]) total_d = '1;
        else                   total_d = total_sum[31:0];
    end

    always_ff @(posedge clk) begin
        if (rst) total_q <= '0;
        else     total_q <= total_d;
    end

    assign total_bits = total_q;
`endif
endmodule

// File: tb/tb_deflate_bit_reader.sv
// Bench for deflate_bit_reader: bit-queue reference model checked every cycle plus directed literals.
module tb_deflate_bit_reader;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         in_valid = 1'b0;
    logic [511:0] in_data = '0;
    logic         in_last = 1'b0;
    logic [8:0]   in_last_len = 9'd0;
    logic         in_ready;
    logic [5:0]   consume_len = 6'd0;
    logic         align_req = 1'b0;
    logic [31:0]  win_data;
    logic         win_valid;
    logic [10:0]  fill_bits;
    logic         done;
    logic         err;
`ifdef BIT_READER_STATS_EN
    logic [31:0]  total_bits;
`endif

    deflate_bit_reader #(.WIN_W(32), .BUF_W(1024)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_last_len(in_last_len), .in_ready(in_ready),
        .consume_len(consume_len), .align_req(align_req), .win_data(win_data),
        .win_valid(win_valid), .fill_bits(fill_bits), .done(done), .err(err)
`ifdef BIT_READER_STATS_EN
        , .total_bits(total_bits)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the buffer is a plain queue of stream bits, head = next bit to consume.
    localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;
    bit     mq[$];
    int     mst = M_IDLE;
    bit     merr = 1'b0;
    bit     mdone = 1'b0;
    int     mbitpos = 0;
    longint mtot = 0;

    always @(posedge clk) begin : model
        int sz, c, n, d, nb;
        bit wv, rdy, so;
        if (rst) begin
            mq.delete();
            mst = M_IDLE; merr = 1'b0; mdone = 1'b0; mbitpos = 0; mtot = 0;
        end else begin
            sz  = mq.size();
            wv  = (sz >= 32) || (mst == M_DRAIN && sz != 0);
            rdy = (mst == M_RUN) && (sz <= 512);
            so  = start && (mst == M_IDLE || mst == M_DONE);
            mdone = 1'b0;
            c = int'(consume_len);
            if (c > 32 || c > sz || (c != 0 && !wv)) merr = 1'b1;
            n = (c > sz) ? sz : c;
            repeat (n) void'(mq.pop_front());
            mbitpos = (mbitpos + n) % 8;
            d = align_req ? (8 - mbitpos) % 8 : 0;
            if (d > mq.size()) begin
                merr = 1'b1;
                d = mq.size();
            end
            repeat (d) void'(mq.pop_front());
            mbitpos = (mbitpos + d) % 8;
            mtot = mtot + n + d;
            if (mtot > 64'hFFFF_FFFF) mtot = 64'hFFFF_FFFF;
            if (in_valid && rdy) begin
                nb = (!in_last || in_last_len == 9'd0) ? 512 : int'(in_last_len);
                for (int i = 0; i < nb; i++) mq.push_back(in_data[i]);
            end
            case (mst)
                M_IDLE, M_DONE: if (so) mst = M_RUN;
                M_RUN:          if (in_valid && rdy && in_last) mst = M_DRAIN;
                M_DRAIN: begin
                    if (mq.size() == 0) begin
                        mst = M_DONE;
                        mdone = 1'b1;
                    end
                end
                default: mst = M_IDLE;
            endcase
            if (so) begin
                merr = 1'b0; mbitpos = 0; mtot = 0;
            end
        end
    end

    always @(negedge clk) begin : cmp
        logic [31:0] ew;
        int sz;
        if (chk_en) begin
            sz = mq.size();
            ew = '0;
            for (int i = 0; i < 32; i++) if (i < sz) ew[i] = mq[i];
            check("fill_bits", {53'd0, fill_bits}, 64'(sz));
            check("win_data", {32'd0, win_data}, {32'd0, ew});
            check("win_valid", {63'd0, win_valid}, {63'd0, (sz >= 32) || (mst == M_DRAIN && sz != 0)});
            check("in_ready", {63'd0, in_ready}, {63'd0, (mst == M_RUN) && (sz <= 512)});
            check("done", {63'd0, done}, {63'd0, mdone});
            check("err", {63'd0, err}, {63'd0, merr});
`ifdef BIT_READER_STATS_EN
            check("total_bits", {32'd0, total_bits}, 64'(mtot));
`endif
        end
    end

    task automatic idle_inputs();
        start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_last_len = 9'd0;
        consume_len = 6'd0; align_req = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    logic [511:0] w0, w1, w2;

    initial begin
        w0 = {16{32'h0123_4567}};
        w1 = {16{32'hDEAD_BEEF}};
        w2 = {16{32'hCAFE_F00D}};

        step();
        step();
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset_fill", {53'd0, fill_bits}, 64'd0);
        check("reset_ready", {63'd0, in_ready}, 64'd0);

        // 1: one 40-bit final word of 0xA5, consumed 8 bits per cycle
        do_start();
        in_valid = 1'b1; in_last = 1'b1; in_last_len = 9'd40; in_data = {64{8'hA5}};
        step();
        in_valid = 1'b0; in_last = 1'b0;
        check("t1_fill40", {53'd0, fill_bits}, 64'd40);
        for (int k = 0; k < 5; k++) begin
            check("t1_byte", {56'd0, win_data[7:0]}, 64'hA5);
            consume_len = 6'd8;
            step();
            if (k == 1) check("t1_masked", {32'd0, win_data}, 64'h00A5_A5A5);
        end
        consume_len = 6'd0;
        check("t1_fill0", {53'd0, fill_bits}, 64'd0);
        check("t1_done", {63'd0, done}, 64'd1);
        step();
        check("t1_done_pulse", {63'd0, done}, 64'd0);

        // 2: two full words fill the buffer; a third waits until fill drops to 512
        do_start();
        in_valid = 1'b1; in_data = w0;
        step();
        in_data = w1;
        step();
        check("t2_fill1024", {53'd0, fill_bits}, 64'd1024);
        check("t2_notready", {63'd0, in_ready}, 64'd0);
        in_data = w2; start = 1'b1;
        step();
        start = 1'b0;
        check("t2_held", {53'd0, fill_bits}, 64'd1024);
        consume_len = 6'd32;
        for (int k = 0; k < 16; k++) step();
        consume_len = 6'd0;
        check("t2_fill512", {53'd0, fill_bits}, 64'd512);
        check("t2_ready", {63'd0, in_ready}, 64'd1);
        check("t2_w1_head", {32'd0, win_data}, 64'hDEAD_BEEF);
        step();
        in_valid = 1'b0;
        check("t2_refill", {53'd0, fill_bits}, 64'd1024);

        // 3: over-consume in DRAIN
        do_reset();
        do_start();
        in_valid = 1'b1; in_last = 1'b1; in_last_len = 9'd20; in_data = {16{32'h000A_BCDE}};
        step();
        in_valid = 1'b0; in_last = 1'b0;
        check("t3_win", {32'd0, win_data}, 64'h000A_BCDE);
        consume_len = 6'd25;
        step();
        consume_len = 6'd0;
        check("t3_err", {63'd0, err}, 64'd1);
        check("t3_fill0", {53'd0, fill_bits}, 64'd0);
        check("t3_done", {63'd0, done}, 64'd1);

        // 4: byte alignment after a 3-bit consume
        do_start();
        check("t4_err_cleared", {63'd0, err}, 64'd0);
        in_valid = 1'b1; in_data = w2;
        step();
        in_valid = 1'b0;
        consume_len = 6'd3;
        step();
        consume_len = 6'd0;
        check("t4_fill509", {53'd0, fill_bits}, 64'd509);
        align_req = 1'b1;
        step();
        check("t4_align5", {53'd0, fill_bits}, 64'd504);
        step();
        align_req = 1'b0;
        check("t4_align0", {53'd0, fill_bits}, 64'd504);

        // 5: in_last_len=0 means a full 512-bit final word, accepted while consuming 32
        do_reset();
        do_start();
        in_valid = 1'b1; in_data = w0;
        step();
        in_data = w1; in_last = 1'b1; in_last_len = 9'd0; consume_len = 6'd32;
        step();
        in_valid = 1'b0; in_last = 1'b0;
        check("t5_fill992", {53'd0, fill_bits}, 64'd992);
        for (int k = 0; k < 31; k++) step();
        consume_len = 6'd0;
        check("t5_drained", {53'd0, fill_bits}, 64'd0);
        check("t5_done", {63'd0, done}, 64'd1);

        // 6: reset in the middle of RUN at fill 700
        do_reset();
        do_start();
        in_valid = 1'b1; in_data = w1;
        step();
        in_data = w2;
        step();
        in_valid = 1'b0;
        consume_len = 6'd32;
        for (int k = 0; k < 10; k++) step();
        consume_len = 6'd4;
        step();
        consume_len = 6'd0;
        check("t6_fill700", {53'd0, fill_bits}, 64'd700);
`ifdef BIT_READER_STATS_EN
        check("t6_total324", {32'd0, total_bits}, 64'd324);
`endif
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_fill0", {53'd0, fill_bits}, 64'd0);
        check("t6_ready0", {63'd0, in_ready}, 64'd0);
        check("t6_wvalid0", {63'd0, win_valid}, 64'd0);
`ifdef BIT_READER_STATS_EN
        check("t6_total0", {32'd0, total_bits}, 64'd0);
`endif
        in_valid = 1'b1; in_data = w0;
        step();
        in_valid = 1'b0;
        check("t6_idle_ignore", {53'd0, fill_bits}, 64'd0);
        check("t6_idle_noerr", {63'd0, err}, 64'd0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
